// File: rtl/down_timer_if.sv
// Load handshake bundle for down_timer: the producer offers a value, and the timer accepts it when ready.
interface down_timer_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with a prescaler, a one-cycle done pulse and optional auto-reload.
module down_timer #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    down_timer_if.slave        load,
    input  logic               start,
    input  logic               stop,
    input  logic               reload_en,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   data,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, LOADED, RUN} state_t;

    state_t             state;
    logic [WIDTH-1:0]   reload_val;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_lat;
    logic               load_fire;

    assign load.ready = (state != RUN);
    assign busy       = (state == RUN);
    assign load_fire  = load.valid && load.ready;

    // NOTE: every register here is assigned with <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data       <= '0;
            reload_val <= '0;
            presc_cnt  <= '0;
            presc_lat  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, LOADED: begin
                    if (load_fire) begin
                        data       <= load.data;
                        reload_val <= load.data;
                        state      <= LOADED;
                    end else if (state == LOADED && start) begin
                        if (data == '0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state     <= RUN;
                            presc_cnt <= '0;
                            presc_lat <= presc;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= LOADED;
                    end else if (presc_cnt == presc_lat) begin
                        presc_cnt <= '0;
                        // The count never drops below 1 while running, so 1 is the expiry point.
                        if (data > WIDTH'(1)) begin
                            data <= data - WIDTH'(1);
                        end else if (data == WIDTH'(1)) begin
                            done <= 1'b1;
                            if (reload_en) begin
                                data <= reload_val;
                            end else begin
                                data  <= '0;
                                state <= IDLE;
                            end
                        end
                    end else begin
                        presc_cnt <= presc_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized stimulus against a cycle model.
module tb_down_timer;
    localparam int WIDTH   = 8;
    localparam int PRESC_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               reload_en;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   data;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    down_timer_if #(.WIDTH(WIDTH)) load_bus ();

    down_timer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load_bus),
        .start     (start),
        .stop      (stop),
        .reload_en (reload_en),
        .presc     (presc),
        .data      (data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: a timer that counts cycles remaining until the next tick.
    int unsigned m_data, m_reload, m_presc, m_wait;
    bit          m_run, m_loaded, m_done;

    function automatic void model_step();
        bit nd = 1'b0;
        if (rst) begin
            m_run = 0; m_loaded = 0; m_data = 0; m_reload = 0; m_presc = 0; m_done = 0;
            return;
        end
        if (!m_run) begin
            if (load_bus.valid) begin
                m_data   = int'(load_bus.data);
                m_reload = m_data;
                m_loaded = 1;
            end else if (start && m_loaded) begin
                if (m_data == 0) begin
                    nd = 1; m_loaded = 0;
                end else begin
                    m_run = 1; m_presc = int'(presc); m_wait = m_presc + 1;
                end
            end
        end else if (stop) begin
            m_run = 0; m_loaded = 1;
        end else begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_wait = m_presc + 1;
                if (m_data > 1) m_data = m_data - 1;
                else begin
                    nd = 1;
                    if (reload_en) m_data = m_reload;
                    else begin m_data = 0; m_run = 0; m_loaded = 0; end
                end
            end
        end
        m_done = nd;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("data", 32'(data), m_data);
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
        check("load_ready", 32'(load_bus.ready), 32'(!m_run));
        if (done === 1'b1) done_seen++;
    endtask

    task automatic quiet();
        rst = 0; start = 0; stop = 0; load_bus.valid = 0;
    endtask

    task automatic load_value(input int v);
        load_bus.valid = 1; load_bus.data = WIDTH'(v);
        step();
        load_bus.valid = 0;
    endtask

    task automatic kick(input int p);
        presc = PRESC_W'(p); start = 1;
        step();
        start = 0;
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; reload_en = 0; presc = '0;
        load_bus.valid = 0; load_bus.data = '0;
        @(negedge clk);
        step();
        quiet();

        // Reset mid-count aborts without a done pulse
        load_value(5);
        kick(0);
        step(); step();
        rst = 1; step(); rst = 0;
        check("rst_data", 32'(data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(load_bus.ready), 1);

        // Load 5, no prescale: 4,3,2,1,0 then one done
        load_value(5);
        kick(0);
        done_seen = 0;
        repeat (6) step();
        check("t2_done_count", 32'(done_seen), 1);
        check("t2_final", 32'(data), 0);

        // Load 2, prescale 3: one done, 8 cycles after start
        load_value(2);
        kick(3);
        done_seen = 0;
        repeat (7) step();
        check("t3_early_done", 32'(done_seen), 0);
        step();
        check("t3_done_at_8", 32'(done), 1);
        repeat (2) step();
        check("t3_done_count", 32'(done_seen), 1);

        // Auto-reload of 3, then release reload
        load_value(3);
        reload_en = 1;
        kick(0);
        done_seen = 0;
        repeat (9) step();
        check("t4_done_count", 32'(done_seen), 3);
        check("t4_busy", 32'(busy), 1);
        check("t4_reloaded", 32'(data), 3);
        reload_en = 0;
        repeat (3) step();
        check("t4_idle_busy", 32'(busy), 0);
        check("t4_idle_data", 32'(data), 0);

        // Stop at 4, loads ignored while running, resume
        load_value(10);
        kick(0);
        load_bus.valid = 1; load_bus.data = WIDTH'(99);
        repeat (6) step();
        load_bus.valid = 0; stop = 1;
        step();
        stop = 0;
        check("t5_held", 32'(data), 4);
        check("t5_ready", 32'(load_bus.ready), 1);
        kick(0);
        step();
        check("t5_resumed", 32'(data), 3);
        repeat (4) step();

        // Edge cases
        rst = 1; step(); rst = 0;
        kick(0);
        check("t6_idle_start", 32'(busy), 0);
        load_value(0);
        kick(0);
        check("t6_zero_done", 32'(done), 1);
        check("t6_zero_busy", 32'(busy), 0);
        step();
        check("t6_zero_pulse", 32'(done), 0);
        load_value(7);
        load_bus.valid = 1; load_bus.data = WIDTH'(9); start = 1;
        step();
        quiet();
        check("t6_load_wins", 32'(data), 9);
        check("t6_stay_loaded", 32'(busy), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            load_bus.valid = ($urandom_range(0, 7) == 0);
            load_bus.data  = WIDTH'($urandom_range(0, 6));
            start          = ($urandom_range(0, 3) == 0);
            stop           = ($urandom_range(0, 15) == 0);
            reload_en      = $urandom_range(0, 1) != 0;
            presc          = PRESC_W'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
